// File: rtl/imem_port_arbiter_if.sv
// Shared-memory port bundle: IF fetch, DM load/store, memory side.
// Arbiter uses the slave view; requesters/memory use master.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              PC_write_enable;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [CNT_W-1:0]  conflict_count;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output PC_write_enable,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output conflict_count
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  PC_write_enable,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  conflict_count
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// IF/DM arbiter for one synchronous-read memory port.
// DM has priority; a starvation counter bounds IF stall.
module imem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 16
) (
  input logic CLK,
  input logic RESET,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e           r_owner;
  owner_e           w_owner_nxt;
  logic [3:0]       r_starve;
  logic [CNT_W-1:0] r_conflict;
  logic             w_sat;
  logic             w_if_sel;
  logic             w_dm_sel;
  logic             w_if_gnt;
  logic             w_dm_gnt;
  logic             w_both;

  assign w_both = bus.if_req & bus.dm_req;

  // Winner select: DM first unless IF has waited STARVE_LIMIT cycles.
  always_comb begin
    w_sat    = (r_starve == LIMIT);
    w_if_sel = bus.if_req & (~bus.dm_req | w_sat);
    w_dm_sel = bus.dm_req & ~w_if_sel;
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (!RESET) begin
      unique case (1'b1)
        w_if_sel: w_if_gnt = 1'b1;
        w_dm_sel: w_dm_gnt = 1'b1;
        default:  ;
      endcase
    end
  end

  // Read-owner state register.
  always_ff @(posedge CLK) begin
    r_owner <= w_owner_nxt;
  end

  // Next owner: whoever issued a read this cycle.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    unique case (1'b1)
      RESET:                   w_owner_nxt = OWN_NONE;
      w_if_gnt:                w_owner_nxt = OWN_IF;
      w_dm_gnt && !bus.dm_we:  w_owner_nxt = OWN_DM;
      default:                 w_owner_nxt = OWN_NONE;
    endcase
  end

  // Memory port mux and return routing.
  always_comb begin
    bus.mem_en    = w_if_gnt | w_dm_gnt;
    bus.mem_we    = w_dm_gnt & bus.dm_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      w_if_gnt: bus.mem_addr = bus.if_addr;
      w_dm_gnt: begin
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
      end
      default: ;
    endcase
    bus.if_gnt          = w_if_gnt;
    bus.dm_gnt          = w_dm_gnt;
    bus.PC_write_enable = w_if_gnt;
    bus.if_rvalid       = (r_owner == OWN_IF) & ~RESET;
    bus.dm_rvalid       = (r_owner == OWN_DM) & ~RESET;
    bus.if_rdata        = bus.mem_rdata;
    bus.dm_rdata        = bus.mem_rdata;
    bus.conflict_count  = r_conflict;
  end

  // Consecutive IF denials, clamped at the limit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_starve <= 4'd0;
    end else if (!bus.if_req || w_if_gnt) begin
      r_starve <= 4'd0;
    end else if (w_dm_gnt && (r_starve < LIMIT)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Saturating contention counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_conflict <= '0;
    end else if (w_both && (r_conflict != '1)) begin
      r_conflict <= r_conflict + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural memory.
// Second instance uses a 4-bit contention counter.
module tb_imem_port_arbiter;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;

  imem_port_arbiter_if #(.ADDR_W(12), .CNT_W(16)) bus ();
  imem_port_arbiter_if #(.ADDR_W(12), .CNT_W(4))  bus4 ();

  imem_port_arbiter #(
    .ADDR_W(12), .STARVE_LIMIT(3), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  imem_port_arbiter #(
    .ADDR_W(12), .STARVE_LIMIT(3), .CNT_W(4)
  ) dut4 (
    .CLK(CLK), .RESET(RESET), .bus(bus4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: unwritten word a reads as 0xA0000000 + a.
  logic [31:0] mem [0:4095];
  bit          written [0:4095];

  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= written[bus.mem_addr] ?
          mem[bus.mem_addr] :
          (32'hA000_0000 + 32'(bus.mem_addr));
      end
    end
  end

  assign bus4.mem_rdata = 32'h0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus4.if_req   = 1'b0;
    bus4.if_addr  = '0;
    bus4.dm_req   = 1'b0;
    bus4.dm_we    = 1'b0;
    bus4.dm_addr  = '0;
    bus4.dm_wdata = '0;
  endtask

  task automatic test_reset;
    idle();
    RESET = 1'b1;
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we,
         bus.PC_write_enable} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_grants got %b exp 00000",
        {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we,
         bus.PC_write_enable});
    end
    n_checks++;
    if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid got %b exp 00",
        {bus.if_rvalid, bus.dm_rvalid});
    end
    n_checks++;
    if (bus.conflict_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_conflict got %0d exp 0",
        bus.conflict_count);
    end
    idle();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_if_stream;
    for (int k = 0; k < 3; k++) begin
      bus.if_req  = 1'b1;
      bus.if_addr = 12'(k);
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.PC_write_enable} !== 2'b11) begin
        n_fail++;
        $display("FAIL if_gnt[%0d] got %b exp 11", k,
          {bus.if_gnt, bus.PC_write_enable});
      end
      if (k > 0) begin
        n_checks++;
        if (bus.if_rvalid !== 1'b1 ||
            bus.if_rdata !== 32'hA000_0000 + 32'(k - 1)) begin
          n_fail++;
          $display("FAIL if_data[%0d] got %b/%h exp 1/%h", k,
            bus.if_rvalid, bus.if_rdata,
            32'hA000_0000 + 32'(k - 1));
        end
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0002) begin
      n_fail++;
      $display("FAIL if_data_last got %b/%h exp 1/a0000002",
        bus.if_rvalid, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_dm_write_read;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 12'd5;
    bus.dm_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({bus.dm_gnt, bus.mem_we} !== 2'b11 || bus.mem_addr !== 12'd5) begin
      n_fail++;
      $display("FAIL dm_wr_gnt got %b addr %0d exp 11 addr 5",
        {bus.dm_gnt, bus.mem_we}, bus.mem_addr);
    end
    tick();
    bus.dm_we = 1'b0;
    #1;
    n_checks++;
    if (bus.dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL dm_wr_norvalid got %b exp 0", bus.dm_rvalid);
    end
    n_checks++;
    if ({bus.dm_gnt, bus.mem_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL dm_rd_gnt got %b exp 10", {bus.dm_gnt, bus.mem_we});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL dm_rd_data got %b/%h exp 1/deadbeef",
        bus.dm_rvalid, bus.dm_rdata);
    end
    tick();
  endtask

  task automatic test_starvation;
    logic [1:0] exp_g;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 12'd0;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 12'd100;
    bus.dm_wdata = 32'h1234_5678;
    for (int c = 0; c < 12; c++) begin
      exp_g = ((c % 4) == 3) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if ({bus.if_gnt, bus.dm_gnt} !== exp_g) begin
        n_fail++;
        $display("FAIL starve_pat[%0d] if/dm got %b exp %b", c,
          {bus.if_gnt, bus.dm_gnt}, exp_g);
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (bus.conflict_count !== 16'd12) begin
      n_fail++;
      $display("FAIL starve_conflict got %0d exp 12", bus.conflict_count);
    end
    tick();
  endtask

  task automatic test_simultaneous;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 12'd7;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'd9;
    #1;
    n_checks++;
    if ({bus.if_gnt, bus.dm_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_first if/dm got %b exp 01",
        {bus.if_gnt, bus.dm_gnt});
    end
    tick();
    bus.dm_req = 1'b0;
    #1;
    n_checks++;
    if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hA000_0009 ||
        bus.if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_dm_ret got dv %b %h iv %b exp 1 a0000009 0",
        bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid);
    end
    n_checks++;
    if ({bus.if_gnt, bus.dm_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_second if/dm got %b exp 10",
        {bus.if_gnt, bus.dm_gnt});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0007 ||
        bus.dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_if_ret got iv %b %h dv %b exp 1 a0000007 0",
        bus.if_rvalid, bus.if_rdata, bus.dm_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid_read;
    bus.if_req  = 1'b1;
    bus.if_addr = 12'd3;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b1;
    #1;
    n_checks++;
    if (bus.dm_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre got dm_gnt %b exp 1", bus.dm_gnt);
    end
    tick();
    bus.dm_req = 1'b0;
    #1;
    n_checks++;
    if (bus.if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ifgnt got %b exp 1", bus.if_gnt);
    end
    tick();
    bus.if_req = 1'b0;
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({bus.if_rvalid, bus.dm_rvalid, bus.if_gnt, bus.dm_gnt,
         bus.mem_en, bus.PC_write_enable} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_outs got %b exp 000000",
        {bus.if_rvalid, bus.dm_rvalid, bus.if_gnt, bus.dm_gnt,
         bus.mem_en, bus.PC_write_enable});
    end
    tick();
    RESET = 1'b0;
    #1;
    n_checks++;
    if (bus.if_rvalid !== 1'b0 || bus.conflict_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_after got iv %b cnt %0d exp 0 0",
        bus.if_rvalid, bus.conflict_count);
    end
    tick();
  endtask

  task automatic test_saturate;
    logic [3:0] exp_c;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus4.if_req = 1'b1;
    bus4.dm_req = 1'b1;
    bus4.dm_we  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_c = (c < 15) ? 4'(c) : 4'd15;
      n_checks++;
      if (bus4.conflict_count !== exp_c) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d] got %0d exp %0d", c,
          bus4.conflict_count, exp_c);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET    = 1'b1;
    idle();
    test_reset();
    test_if_stream();
    test_dm_write_read();
    test_starvation();
    test_simultaneous();
    test_reset_mid_read();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
